// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump reader.
// Also holds the register names used by the bank and display logic.
package reg_dump_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_IDX_W-1:0] V0  = 5'd2;
  localparam logic [REG_IDX_W-1:0] A0  = 5'd4;
  localparam logic [REG_IDX_W-1:0] SPR = 5'd29;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SEND,
    DONE,
    GAP
  } state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Pair stream (index, value) with valid/ready handshake.
// master: oValid/oIndex/oData out, iReady in; slave is the mirror.
interface reg_dump_reader_if;
  import reg_dump_pkg::*;

  logic                  oValid;
  logic                  iReady;
  logic [REG_IDX_W-1:0]  oIndex;
  logic [REG_DATA_W-1:0] oData;

  modport master (
    output oValid,
    output oIndex,
    output oData,
    input  iReady
  );

  modport slave (
    input  oValid,
    input  oIndex,
    input  oData,
    output iReady
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register bank aux read port FIRST_REG..LAST_REG and streams
// (index, value) pairs on `pair`.
// Ports: iCLK, iCLR (sync, active high), iStart, iAuto, oRegSelect,
// iRegData, pair (master), oBusy, oDone.
// Option: REG_DUMP_SKIP_ZERO_EN drops pairs whose value is zero.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int AUTO_GAP  = 1024
) (
  input  logic                  iCLK,
  input  logic                  iCLR,
  input  logic                  iStart,
  input  logic                  iAuto,
  output logic [REG_IDX_W-1:0]  oRegSelect,
  input  logic [REG_DATA_W-1:0] iRegData,
  reg_dump_reader_if.master     pair,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);
  localparam logic [15:0]          GAP_INIT  = 16'(AUTO_GAP);

  state_e                state_q, state_n;
  logic [REG_IDX_W-1:0]  idx_q, idx_n;
  logic                  valid_q, valid_n;
  logic [REG_IDX_W-1:0]  oidx_q, oidx_n;
  logic [REG_DATA_W-1:0] data_q, data_n;
  logic [15:0]           gap_q, gap_n;
  logic                  skip;

`ifdef REG_DUMP_SKIP_ZERO_EN
  assign skip = (iRegData == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iCLR) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      oidx_q  <= oidx_n;
      data_q  <= data_n;
      gap_q   <= gap_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    oidx_n  = oidx_q;
    data_n  = data_q;
    gap_n   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (iStart || iAuto) begin
          state_n = SETTLE;
          idx_n   = FIRST_IDX;
        end
      end
      SETTLE: begin
        // select has had a full cycle through the bank mux: capture now
        if (skip) begin
          if (idx_q == LAST_IDX) state_n = DONE;
          else idx_n = idx_q + 1'b1;
        end else begin
          data_n  = iRegData;
          oidx_n  = idx_q;
          valid_n = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (pair.iReady) begin
          valid_n = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx_q + 1'b1;
            state_n = SETTLE;
          end
        end
      end
      DONE: begin
        if (iAuto) begin
          state_n = GAP;
          gap_n   = GAP_INIT;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        gap_n = gap_q - 1'b1;
        if (!iAuto) begin
          state_n = IDLE;
          gap_n   = '0;
        end else if (gap_q == 16'd1) begin
          state_n = SETTLE;
          idx_n   = FIRST_IDX;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign oRegSelect  = idx_q;
  assign pair.oValid = valid_q;
  assign pair.oIndex = oidx_q;
  assign pair.oData  = data_q;
  assign oBusy = (state_q == SETTLE) ||
                 (state_q == SEND) ||
                 (state_q == DONE);
  assign oDone = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: two instances (full range with
// AUTO_GAP=4, and range 2..4), random banks, model-driven expectations.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } pair_t;

  logic        clk;
  logic        rst;
  logic        start_a, auto_a, start_b;
  logic [4:0]  sel_a, sel_b;
  logic [31:0] rd_a, rd_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] bank_a [32];
  logic [31:0] bank_b [32];
  logic        ready_ctl, bp_en, bp_bit;
  logic        prev_done_a, prev_done_b;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt_a = 0, done_cnt_b = 0;
  int          exp_done_a = 0, exp_done_b = 0;
  pair_t       qa[$];
  pair_t       qb[$];

  reg_dump_reader_if aif ();
  reg_dump_reader_if bif ();

  assign aif.iReady = bp_en ? bp_bit : ready_ctl;
  assign bif.iReady = 1'b1;
  assign rd_a = bank_a[sel_a];
  assign rd_b = bank_b[sel_b];

  reg_dump_reader #(
    .FIRST_REG(0), .LAST_REG(31), .AUTO_GAP(4)
  ) u_a (
    .iCLK(clk), .iCLR(rst), .iStart(start_a), .iAuto(auto_a),
    .oRegSelect(sel_a), .iRegData(rd_a), .pair(aif.master),
    .oBusy(busy_a), .oDone(done_a)
  );

  reg_dump_reader #(
    .FIRST_REG(2), .LAST_REG(4), .AUTO_GAP(4)
  ) u_b (
    .iCLK(clk), .iCLR(rst), .iStart(start_b), .iAuto(1'b0),
    .oRegSelect(sel_b), .iRegData(rd_b), .pair(bif.master),
    .oBusy(busy_b), .oDone(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event/timeout, expected none", nm);
  endtask

  // Reference: every index in range, value as held in the bank now.
  task automatic push_a();
    for (int i = 0; i < 32; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (bank_a[i] == 32'h0) continue;
`endif
      qa.push_back('{idx: 5'(i), data: bank_a[i]});
    end
    exp_done_a++;
  endtask

  task automatic push_b();
    for (int i = 2; i <= 4; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (bank_b[i] == 32'h0) continue;
`endif
      qb.push_back('{idx: 5'(i), data: bank_b[i]});
    end
    exp_done_b++;
  endtask

  initial begin
    bp_bit = 1'b1;
    forever begin
      @(negedge clk);
      bp_bit = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : mon_a
    pair_t e;
    prev_done_a = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (done_a) begin
        done_cnt_a++;
        if (prev_done_a) bad("a_done_width");
      end
      prev_done_a = done_a;
      if (aif.oValid && aif.iReady) begin
        if (qa.size() == 0) begin
          bad("a_unexpected_pair");
        end else begin
          e = qa.pop_front();
          chk("a_index", 32'(aif.oIndex), 32'(e.idx));
          chk("a_data", aif.oData, e.data);
        end
      end
    end
  end

  initial begin : mon_b
    pair_t e;
    prev_done_b = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (done_b) begin
        done_cnt_b++;
        if (prev_done_b) bad("b_done_width");
      end
      prev_done_b = done_b;
      if (bif.oValid && bif.iReady) begin
        if (qb.size() == 0) begin
          bad("b_unexpected_pair");
        end else begin
          e = qb.pop_front();
          chk("b_index", 32'(bif.oIndex), 32'(e.idx));
          chk("b_data", bif.oData, e.data);
        end
      end
    end
  end

  // Returns the cycle number (edge count + 1) at which oDone was seen.
  task automatic wait_done(input bit use_b, input int budget,
                           output int c);
    bit seen;
    seen = 0;
    c = -1;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        seen = 1;
        c = cyc + 1;
      end
    end
    if (!seen) bad(use_b ? "b_done_timeout" : "a_done_timeout");
  endtask

  task automatic wait_sel_a(input logic [4:0] s, input logic v);
    bit seen;
    seen = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (sel_a == s && aif.oValid == v) seen = 1;
    end
    if (!seen) bad("a_select_timeout");
  endtask

  task automatic pulse_start_a(output int k);
    @(negedge clk);
    start_a = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic fill_rand_a();
    for (int i = 0; i < 32; i++)
      bank_a[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endtask

  initial begin : stim
    int k, d1, d2, d3, fv;
    rst = 1'b1;
    start_a = 1'b0;
    auto_a = 1'b0;
    start_b = 1'b0;
    ready_ctl = 1'b1;
    bp_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bank_a[i] = 32'(i * 16);
      bank_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(aif.oValid), 32'd0);
    chk("rst_index", 32'(aif.oIndex), 32'd0);
    chk("rst_data", aif.oData, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_sel_a", 32'(sel_a), 32'd0);
    chk("rst_sel_b", 32'(sel_b), 32'd2);

    // full scan, reg[i] = i*16, ready held high
    push_a();
    pulse_start_a(k);
    fv = -1;
    for (int t = 0; t < 10 && fv < 0; t++) begin
      if (aif.oValid) fv = cyc + 1;
      else @(negedge clk);
    end
    wait_done(0, 200, d1);
`ifndef REG_DUMP_SKIP_ZERO_EN
    chk("first_valid_cycle", 32'(fv), 32'(k + 2));
    chk("done_cycle", 32'(d1), 32'(k + 65));
`endif
    @(negedge clk);
    chk("scan1_drained", 32'(qa.size()), 32'd0);

    // stall at index 29, write reg29 while the pair is pending
    for (int i = 0; i < 32; i++) bank_a[i] = $urandom | 32'h1;
    bank_a[29] = 32'h7FFF_EFFC;
    push_a();
    pulse_start_a(k);
    wait_sel_a(5'd29, 1'b0);
    ready_ctl = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_valid", 32'(aif.oValid), 32'd1);
      chk("stall_index", 32'(aif.oIndex), 32'd29);
      chk("stall_data", aif.oData, 32'h7FFF_EFFC);
      if (j == 1) bank_a[29] = 32'h0000_1234;
    end
    ready_ctl = 1'b1;
    wait_done(0, 200, d1);
    @(negedge clk);
    chk("stall_drained", 32'(qa.size()), 32'd0);

    // reset while presenting index 10
    fill_rand_a();
    bank_a[10] = 32'hA5A5_0010;
    push_a();
    pulse_start_a(k);
    wait_sel_a(5'd10, 1'b0);
    ready_ctl = 1'b0;
    @(negedge clk);
    chk("clr_pre_valid", 32'(aif.oValid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("clr_valid", 32'(aif.oValid), 32'd0);
    chk("clr_busy", 32'(busy_a), 32'd0);
    chk("clr_sel", 32'(sel_a), 32'd0);
    qa.delete();
    exp_done_a--;
    ready_ctl = 1'b1;
    repeat (10) @(negedge clk);
    chk("clr_no_done", 32'(done_cnt_a), 32'(exp_done_a));
    push_a();
    pulse_start_a(k);
    wait_done(0, 200, d1);
    @(negedge clk);
    chk("restart_drained", 32'(qa.size()), 32'd0);

    // auto mode: back-to-back scans, then drop iAuto mid-scan
    for (int i = 0; i < 32; i++) bank_a[i] = $urandom | 32'h1;
    push_a();
    @(negedge clk);
    auto_a = 1'b1;
    wait_done(0, 200, d1);
    push_a();
    wait_done(0, 200, d2);
`ifndef REG_DUMP_SKIP_ZERO_EN
    chk("auto_spacing", 32'(d2 - d1), 32'd69);
`endif
    push_a();
    wait_sel_a(5'd15, 1'b1);
    auto_a = 1'b0;
    wait_done(0, 200, d3);
    repeat (10) @(negedge clk);
    chk("auto_idle_busy", 32'(busy_a), 32'd0);
    chk("auto_drained", 32'(qa.size()), 32'd0);
    chk("auto_done_count", 32'(done_cnt_a), 32'(exp_done_a));

    // sparse bank: only reg2 and the stack pointer are nonzero
    for (int i = 0; i < 32; i++) bank_a[i] = 32'h0;
    bank_a[V0] = 32'd5;
    bank_a[SPR] = 32'h7FFF_EFFC;
    push_a();
    pulse_start_a(k);
    wait_done(0, 200, d1);
    @(negedge clk);
    chk("sparse_drained", 32'(qa.size()), 32'd0);

    // random banks under random backpressure
    bp_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      fill_rand_a();
      push_a();
      pulse_start_a(k);
      wait_done(0, 600, d1);
      @(negedge clk);
      chk("rand_drained", 32'(qa.size()), 32'd0);
    end
    bp_en = 1'b0;

    // narrow range instance: indices 2..4
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++)
        bank_b[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      push_b();
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_done(1, 50, d1);
      @(negedge clk);
      chk("b_drained", 32'(qb.size()), 32'd0);
    end
    repeat (5) @(negedge clk);
    chk("a_done_total", 32'(done_cnt_a), 32'(exp_done_a));
    chk("b_done_total", 32'(done_cnt_b), 32'(exp_done_b));
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
